regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, legal 1..4: number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, legal 1..2: number of write ports.
REQ-005 SHALL have parameter ZERO_R0, default 1: when 1, register 0 is hardwired to zero.
REQ-006 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port write, input, NUM_WR: per-port write enable.
REQ-009 SHALL have port write_reg, input, NUM_WR*ADDR_W: per-port write address; port k occupies slice k.
REQ-010 SHALL have port write_data, input, NUM_WR*DATA_W: per-port write data; port k occupies slice k.
REQ-011 SHALL have port read_reg, input, NUM_RD*ADDR_W: per-port read address.
REQ-012 SHALL have port read_data, output, NUM_RD*DATA_W: per-port read data.
REQ-013 SHALL have port busy, output, 1: high while the clear sequencer runs.

Function
REQ-014 Reads SHALL be combinational: read_data slice k = register[read_reg slice k] in the same cycle.
REQ-015 Write port k SHALL update register[write_reg k] with write_data k on a rising edge when write[k]=1 and busy=0.
REQ-016 When both write ports target the same address in the same cycle, port 1 SHALL win.
REQ-017 With ZERO_R0=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0.
REQ-018 A clear sequencer SHALL have two states: CLEAR and IDLE.
REQ-019 In CLEAR, the sequencer SHALL zero register[ptr] on each cycle and increment ptr; on ptr = DEPTH-1 it SHALL move to IDLE. CLEAR therefore lasts exactly DEPTH cycles after reset deasserts.
REQ-020 busy SHALL equal 1 in CLEAR and 0 in IDLE.
REQ-021 While busy=1, all writes SHALL be ignored and all read_data SHALL be 0.
REQ-022 Reads and writes to arbitrary addresses SHALL never stall or error; addresses wrap naturally within ADDR_W.

Reset
REQ-023 While reset=1 at a rising edge, state SHALL become CLEAR, ptr SHALL become 0, and busy SHALL be 1 after that edge.
REQ-024 Holding reset SHALL keep ptr at 0; clearing SHALL proceed only after reset deasserts.
REQ-025 Reset asserted mid-CLEAR SHALL restart the sequence from ptr=0.
REQ-026 Reset asserted in IDLE SHALL restart the full DEPTH-cycle clear.
REQ-027 Register contents SHALL NOT be reset in one cycle; they are zeroed only by the sequencer.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined, a read whose address matches an enabled write in the same cycle (busy=0, address not 0 when ZERO_R0=1) SHALL return the winning write_data combinationally.
REQ-030 Without REGFILE_BYPASS_EN, such a read SHALL return the old contents, with the new value visible from the next cycle.

Structure
REQ-031 Package regfile_pkg SHALL hold the default parameter constants (DATA_W, ADDR_W, NUM_RD, NUM_WR) and the clear-state enum (CLEAR, IDLE).
REQ-032 Sub-module regfile_clear_fsm SHALL own the state, ptr and busy, and SHALL expose a clear-enable and clear-address to the storage array.

Verification (defaults: DATA_W=32, ADDR_W=5, NUM_RD=2, NUM_WR=2, ZERO_R0=1)
REQ-033 Hold reset for 5 cycles, then release: busy=1 for exactly 32 cycles, then 0; all reads return 0 during busy and after.
REQ-034 Port0 writes r1=0x2, then r3=0x5, then r7=0x9; next cycle read r3/r1 gives 0x5/0x2, and read r7/r7 gives 0x9/0x9.
REQ-035 Write r0=0x7, then read r0 on both ports: 0x0 on both.
REQ-036 In the same cycle, port0 writes r5=0xA and port1 writes r5=0xB: read r5 gives 0xB next cycle.
REQ-037 Write r9=0x3C while reading r9 in the same cycle: 0x3C in that cycle with REGFILE_BYPASS_EN; 0x0 then 0x3C without it.
REQ-038 Assert reset at clear cycle 10, write r2=0x4 during busy, release reset: busy lasts 32 more cycles, and read r2 gives 0x0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default sizing constants and clear-sequencer state encoding
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clear_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - walks every register address once after reset, zeroing it
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              busy,
  output logic              clear_en,
  output logic [ADDR_W-1:0] clear_addr
);

  clear_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy     = 1'b0;
    clear_en = 1'b0;
    case (state_q)
      CLEAR: begin
        busy     = 1'b1;
        clear_en = 1'b1;
        ptr_d    = ptr_q + ADDR_W'(1);
        // Last address cleared this cycle; ptr wraps back to 0 for the next run.
        if (ptr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign clear_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with post-reset clear sequencer
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int NUM_WR  = DEF_NUM_WR,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        write,
  input  logic [NUM_WR*ADDR_W-1:0] write_reg,
  input  logic [NUM_WR*DATA_W-1:0] write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              clear_en;
  logic [ADDR_W-1:0] clear_addr;
  logic [NUM_WR-1:0] wr_en;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock      (clock),
    .reset      (reset),
    .busy       (busy),
    .clear_en   (clear_en),
    .clear_addr (clear_addr)
  );

  always_comb begin
    wr_en = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_en[k] = write[k] && !busy &&
                 !((ZERO_R0 != 0) && (write_reg[k*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Ascending port order makes the highest-numbered port win on address collisions.
  always_ff @(posedge clock) begin
    if (clear_en) begin
      regs[clear_addr] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k]) regs[write_reg[k*ADDR_W +: ADDR_W]] <= write_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    read_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      ra = read_reg[r*ADDR_W +: ADDR_W];
      rv = regs[ra];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (write_reg[k*ADDR_W +: ADDR_W] == ra)) rv = write_data[k*DATA_W +: DATA_W];
      end
`endif
      if (busy || ((ZERO_R0 != 0) && (ra == '0))) rv = '0;
      read_data[r*DATA_W +: DATA_W] = rv;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed table-driven bench for regfile_mp at default sizing
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  write;
  logic [9:0]  write_reg;
  logic [63:0] write_data;
  logic [9:0]  read_reg;
  logic [63:0] read_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp dut (
    .clock      (clock),
    .reset      (reset),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg   (read_reg),
    .read_data  (read_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wr;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wr, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    write      = wr;
    write_reg  = {wa1, wa0};
    write_data = {wd1, wd0};
    read_reg   = {ra1, ra0};
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded).
  task automatic count_busy(output int n, output bit reads_zero);
    n = 0;
    reads_zero = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!busy) break;
      n++;
      if (read_data !== 64'h0) reads_zero = 1'b0;
      read_reg = read_reg + 10'd33;
      @(negedge clock);
    end
  endtask

  initial begin
    int  n;
    bit  rz;
    bit  allz;

    vecs[0]  = '{2'b01, 5'd1,  32'h2,  5'd0,  32'h0,        5'd0,  5'd2,  32'h0,        32'h0};
    vecs[1]  = '{2'b01, 5'd3,  32'h5,  5'd0,  32'h0,        5'd1,  5'd2,  32'h2,        32'h0};
    vecs[2]  = '{2'b01, 5'd7,  32'h9,  5'd0,  32'h0,        5'd3,  5'd1,  32'h5,        32'h2};
    vecs[3]  = '{2'b00, 5'd0,  32'h0,  5'd0,  32'h0,        5'd7,  5'd7,  32'h9,        32'h9};
    vecs[4]  = '{2'b01, 5'd0,  32'h7,  5'd0,  32'h0,        5'd3,  5'd1,  32'h5,        32'h2};
    vecs[5]  = '{2'b00, 5'd0,  32'h0,  5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[6]  = '{2'b11, 5'd5,  32'hA,  5'd5,  32'hB,        5'd7,  5'd3,  32'h9,        32'h5};
    vecs[7]  = '{2'b00, 5'd0,  32'h0,  5'd0,  32'h0,        5'd5,  5'd0,  32'hB,        32'h0};
    vecs[8]  = '{2'b10, 5'd0,  32'h0,  5'd31, 32'hDEADBEEF, 5'd5,  5'd7,  32'hB,        32'h9};
    vecs[9]  = '{2'b00, 5'd0,  32'h0,  5'd0,  32'h0,        5'd31, 5'd5,  32'hDEADBEEF, 32'hB};
    vecs[10] = '{2'b11, 5'd6,  32'h11, 5'd8,  32'h22,       5'd31, 5'd0,  32'hDEADBEEF, 32'h0};
    vecs[11] = '{2'b00, 5'd6,  32'hFF, 5'd8,  32'hFF,       5'd6,  5'd8,  32'h11,       32'h22};
    vecs[12] = '{2'b00, 5'd0,  32'h0,  5'd0,  32'h0,        5'd6,  5'd9,  32'h11,       32'h0};

    reset = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Reset held for 5 cycles.
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("busy_in_reset", {31'h0, busy}, 32'h1);
    chk("read_in_reset", read_data[31:0] | read_data[63:32], 32'h0);

    reset = 1'b0;
    read_reg = {5'd4, 5'd1};
    count_busy(n, rz);
    chk("busy_len_initial", n, 32);
    chk("reads_zero_busy", {31'h0, rz}, 32'h1);

    allz = 1'b1;
    for (int a = 0; a < 32; a++) begin
      read_reg = {5'(31 - a), 5'(a)};
      #1;
      if (read_data !== 64'h0) allz = 1'b0;
    end
    chk("all_zero_after_clear", {31'h0, allz}, 32'h1);
    @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].wr, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1, vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("vec%0d_rd0", i), read_data[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_rd1", i), read_data[63:32], vecs[i].e1);
      @(negedge clock);
    end

    // Same-cycle write/read of r9: forwarded only with bypass.
    drive(2'b01, 5'd9, 32'h3C, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    chk("byp_r9_p0", read_data[31:0], BYP ? 32'h3C : 32'h0);
    chk("byp_r9_p1", read_data[63:32], BYP ? 32'h3C : 32'h0);
    @(negedge clock);
    drive(2'b11, 5'd10, 32'h1, 5'd10, 32'h2, 5'd10, 5'd9);
    #1;
    chk("byp_r10_collide", read_data[31:0], BYP ? 32'h2 : 32'h0);
    chk("r9_next_cycle", read_data[63:32], 32'h3C);
    @(negedge clock);
    drive(2'b01, 5'd0, 32'h55, 5'd0, 32'h0, 5'd0, 5'd10);
    #1;
    chk("byp_r0_blocked", read_data[31:0], 32'h0);
    chk("r10_port1_wins", read_data[63:32], 32'h2);
    @(negedge clock);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9);
    #1;
    chk("r0_still_zero", read_data[31:0], 32'h0);

    // Reset from IDLE restarts the clear; then reset again at clear cycle 10.
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("busy_after_idle_reset", {31'h0, busy}, 32'h1);
    chk("read_r9_masked_busy", read_data[63:32], 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    chk("busy_at_cycle10", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    drive(2'b01, 5'd2, 32'h4, 5'd0, 32'h0, 5'd2, 5'd9);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    count_busy(n, rz);
    chk("busy_len_restart", n, 32);
    chk("reads_zero_restart", {31'h0, rz}, 32'h1);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd9);
    #1;
    chk("r2_write_ignored", read_data[31:0], 32'h0);
    chk("r9_cleared", read_data[63:32], 32'h0);
    @(negedge clock);
    drive(2'b01, 5'd2, 32'h4, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clock);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd2);
    #1;
    chk("r2_write_after_clear", read_data[31:0], 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
